// File: rtl/el2_pmp_bounds_cache_if.sv
// Bus between the PMP CSR block, the bounds cache and the LSU/IFU range checkers.
// The master drives the CSR view; the slave (bounds cache) returns cached byte-address bounds.
interface el2_pmp_bounds_cache_if #(
  parameter int PMP_ENTRIES = 16
);
  logic                          cfg_update;
  logic [PMP_ENTRIES-1:0][7:0]   pmp_pmpcfg;
  logic [PMP_ENTRIES-1:0][31:0]  pmp_pmpaddr;
  logic [PMP_ENTRIES-1:0][31:0]  region_base;
  logic [PMP_ENTRIES-1:0][31:0]  region_limit;
  logic [PMP_ENTRIES-1:0]        region_en;
  logic                          bounds_valid;
  logic                          busy;

  modport master (
    output cfg_update, pmp_pmpcfg, pmp_pmpaddr,
    input  region_base, region_limit, region_en, bounds_valid, busy
  );

  modport slave (
    input  cfg_update, pmp_pmpcfg, pmp_pmpaddr,
    output region_base, region_limit, region_en, bounds_valid, busy
  );
endinterface

// File: rtl/el2_pmp_bounds_cache.sv
// Walks the PMP entries one per cycle and caches inclusive {base, limit, en} byte bounds,
// so the PMP checkers only need plain 32-bit range compares.
module el2_pmp_bounds_cache #(
  parameter  int PMP_ENTRIES = 16,
  localparam int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  el2_pmp_bounds_cache_if.slave  bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SCAN  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  logic [0:0]                    r_state;
  logic [IDX_W-1:0]              r_idx;
  logic [PMP_ENTRIES-1:0][31:0]  r_base;
  logic [PMP_ENTRIES-1:0][31:0]  r_limit;
  logic [PMP_ENTRIES-1:0]        r_en;

  logic [1:0]   w_mode;
  logic [29:0]  w_a;
  logic [29:0]  w_prev;
  logic [4:0]   w_t;
  logic [31:0]  w_byte;
  logic [31:0]  w_lo;
  logic [31:0]  w_base;
  logic [31:0]  w_limit;
  logic         w_en;
  logic         w_unused;

  // Lock and XWR bits, and pmpaddr[31:30], are read by consumers straight from the CSRs.
  assign w_unused = ^{bus.pmp_pmpcfg, bus.pmp_pmpaddr};

  // Select the entry under the walk pointer and its TOR predecessor from the live CSRs.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_mode = '0;
    w_a    = '0;
    w_prev = '0;
    for (int j = 0; j < PMP_ENTRIES; j++) begin
      if (IDX_W'(j) == r_idx) begin
        w_mode = bus.pmp_pmpcfg[j][4:3];
        w_a    = bus.pmp_pmpaddr[j][29:0];
      end
    end
    for (int j = 0; j < PMP_ENTRIES - 1; j++) begin
      if (IDX_W'(j + 1) == r_idx) begin
        w_prev = bus.pmp_pmpaddr[j][29:0];
      end
    end
  end

  // Trailing-ones count of the word address; 30 means the NAPOT region spans all of memory.
  always_comb begin
    // NOTE: a running count inside one always_comb must use blocking '=' so each iteration sees the last.
    w_t = '0;
    for (int k = 0; k < 30; k++) begin
      if (w_a[k] && (w_t == 5'(k))) begin
        w_t = 5'(k + 1);
      end
    end
  end

  assign w_byte = {w_a, 2'b00};
  assign w_lo   = {w_prev, 2'b00};

  always_comb begin
    w_base  = '0;
    w_limit = '0;
    w_en    = 1'b0;
    case (w_mode)
      A_TOR: begin
        w_base = w_lo;
        if (w_byte <= w_lo) begin
          w_limit = w_lo;
        end else begin
          w_en    = 1'b1;
          w_limit = w_byte - 32'd1;
        end
      end
      A_NA4: begin
        w_en    = 1'b1;
        w_base  = w_byte;
        w_limit = w_byte + 32'd3;
      end
      A_NAPOT: begin
        w_en = 1'b1;
        if (w_t == 5'd30) begin
          w_base  = '0;
          w_limit = 32'hFFFF_FFFF;
        end else begin
          // base is aligned to the region size, so OR-ing the size mask equals base + size - 1.
          w_base  = {w_a & (30'h3FFF_FFFF << (w_t + 5'd1)), 2'b00};
          w_limit = w_base | ~(32'hFFFF_FFFF << ({1'b0, w_t} + 6'd3));
        end
      end
      default: ;
    endcase
  end

  // Walk controller: a CSR write always restarts from entry 0, even on the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SCAN;
      r_idx   <= '0;
      // NOTE: the bounds array is reset on purpose: consumers must never see stale regions after reset.
      r_base  <= '0;
      r_limit <= '0;
      r_en    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_update) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
          end
        end
        default: begin
          for (int j = 0; j < PMP_ENTRIES; j++) begin
            if (IDX_W'(j) == r_idx) begin
              r_base[j]  <= w_base;
              r_limit[j] <= w_limit;
              r_en[j]    <= w_en;
            end
          end
          if (bus.cfg_update) begin
            r_idx <= '0;
          end else if (r_idx == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.region_base  = r_base;
  assign bus.region_limit = r_limit;
  assign bus.region_en    = r_en;
  assign bus.bounds_valid = (r_state == ST_IDLE);
  assign bus.busy         = (r_state == ST_SCAN);

endmodule

// File: tb/tb_el2_pmp_bounds_cache.sv
// Self-checking bench for el2_pmp_bounds_cache: directed PMP decodes, random configs,
// restart timing and async reset, all compared against an arithmetic reference model.
module tb_el2_pmp_bounds_cache;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  el2_pmp_bounds_cache_if #(.PMP_ENTRIES(N)) bus ();
  el2_pmp_bounds_cache    #(.PMP_ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0]  cfg  [N];
  logic [31:0] addr [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.pmp_pmpcfg[i]  = cfg[i];
      bus.pmp_pmpaddr[i] = addr[i];
    end
  endtask

  // Region bounds straight from the PMP rules, using wide integer arithmetic.
  function automatic void model(input int i, output logic [31:0] b,
                                output logic [31:0] l, output logic e);
    longint unsigned a, lo, hi, sz;
    int t;
    a = longint'(addr[i] & 32'h3FFF_FFFF);
    b = '0;
    l = '0;
    e = 1'b0;
    case (cfg[i][4:3])
      2'd1: begin
        lo = (i == 0) ? 0 : longint'(addr[i-1] & 32'h3FFF_FFFF) * 4;
        hi = a * 4;
        b  = 32'(lo);
        if (hi <= lo) l = 32'(lo);
        else begin
          e = 1'b1;
          l = 32'(hi - 1);
        end
      end
      2'd2: begin
        e = 1'b1;
        b = 32'(a * 4);
        l = 32'(a * 4 + 3);
      end
      2'd3: begin
        e = 1'b1;
        t = 0;
        while (t < 30 && a[t]) t++;
        if (t == 30) begin
          b = 32'h0;
          l = 32'hFFFF_FFFF;
        end else begin
          sz = 64'd1 << (t + 3);
          b  = 32'(((a * 4) / sz) * sz);
          l  = 32'(((a * 4) / sz) * sz + sz - 1);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] b, l;
    logic e;
    for (int i = 0; i < N; i++) begin
      model(i, b, l, e);
      check($sformatf("%s_base%0d", tag, i),  bus.region_base[i],  b);
      check($sformatf("%s_limit%0d", tag, i), bus.region_limit[i], l);
      check($sformatf("%s_en%0d", tag, i),    32'(bus.region_en[i]), 32'(e));
    end
  endtask

  // Called at a negedge; counts negedges until bounds_valid, bounded.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.bounds_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_walk_cycles"}, 32'(n), 32'(N));
  endtask

  task automatic pulse(input string tag);
    bus.cfg_update = 1'b1;
    @(negedge clk);
    bus.cfg_update = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.bounds_valid), 32'd0);
    check({tag, "_busy"},       32'(bus.busy),         32'd1);
  endtask

  task automatic apply(input string tag);
    drive();
    pulse(tag);
    wait_valid(tag);
    check_all(tag);
  endtask

  task automatic randomize_cfg();
    int k;
    logic [31:0] ones;
    for (int i = 0; i < N; i++) begin
      cfg[i]  = 8'($urandom);
      addr[i] = $urandom & 32'h3FFF_FFFF;
      if (cfg[i][4:3] == 2'd3 && $urandom_range(0, 1) == 1) begin
        k       = $urandom_range(0, 30);
        ones    = (k == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - k));
        addr[i] = ((addr[i] & ~(32'd1 << k)) | ones) & 32'h3FFF_FFFF;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cfg[i]  = '0;
      addr[i] = '0;
    end
    drive();
    bus.cfg_update = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",  32'(bus.bounds_valid), 32'd0);
    check("rst_busy",   32'(bus.busy),         32'd1);
    check("rst_en",     32'(bus.region_en),    32'd0);
    check("rst_base0",  bus.region_base[0],    32'd0);
    check("rst_limitN", bus.region_limit[N-1], 32'd0);

    // Initial walk with everything OFF
    rst = 1'b0;
    wait_valid("init");
    check("init_busy", 32'(bus.busy), 32'd0);
    check("init_en",   32'(bus.region_en), 32'd0);
    check_all("init");

    // Directed decodes
    cfg[0] = 8'h08; addr[0] = 32'h0000_0100;
    cfg[2] = 8'h00; addr[2] = 32'h0000_0200;
    cfg[3] = 8'h08; addr[3] = 32'h0000_0180;
    cfg[5] = 8'h18; addr[5] = 32'h0000_07FF;
    cfg[6] = 8'h18; addr[6] = 32'h3FFF_FFFF;
    cfg[7] = 8'h10; addr[7] = 32'h3FFF_FFFF;
    cfg[8] = 8'h9F; addr[8] = 32'h0000_1003;
    apply("dir");
    check("tor0_base",    bus.region_base[0],  32'h0000_0000);
    check("tor0_limit",   bus.region_limit[0], 32'h0000_03FF);
    check("tor0_en",      32'(bus.region_en[0]), 32'd1);
    check("tor3_en",      32'(bus.region_en[3]), 32'd0);
    check("tor3_limit",   bus.region_limit[3], 32'h0000_0800);
    // 11 trailing ones -> 16 KiB naturally aligned region
    check("napot5_base",  bus.region_base[5],  32'h0000_0000);
    check("napot5_limit", bus.region_limit[5], 32'h0000_3FFF);
    check("napot6_base",  bus.region_base[6],  32'h0000_0000);
    check("napot6_limit", bus.region_limit[6], 32'hFFFF_FFFF);
    check("na4_7_base",   bus.region_base[7],  32'hFFFF_FFFC);
    check("na4_7_limit",  bus.region_limit[7], 32'hFFFF_FFFF);
    check("na4_7_en",     32'(bus.region_en[7]), 32'd1);

    // Random configurations
    for (int r = 0; r < 6; r++) begin
      randomize_cfg();
      apply($sformatf("rnd%0d", r));
    end

    // Restart at idx 5 and again on the last idx; the final config must win
    randomize_cfg();
    drive();
    pulse("rs_a");
    repeat (5) @(negedge clk);
    randomize_cfg();
    drive();
    pulse("rs_b");
    repeat (N - 1) @(negedge clk);
    check("rs_last_valid", 32'(bus.bounds_valid), 32'd0);
    randomize_cfg();
    drive();
    pulse("rs_c");
    wait_valid("rs_c");
    check_all("rs_c");

    // Async reset in the middle of a walk
    randomize_cfg();
    cfg[0]  = 8'h10;
    addr[0] = ($urandom & 32'h3FFF_FFFF) | 32'h1;
    apply("pre_ar");
    randomize_cfg();
    drive();
    pulse("ar");
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_valid",  32'(bus.bounds_valid), 32'd0);
    check("ar_busy",   32'(bus.busy),         32'd1);
    check("ar_en",     32'(bus.region_en),    32'd0);
    check("ar_base0",  bus.region_base[0],    32'd0);
    check("ar_limit0", bus.region_limit[0],   32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("ar_walk");
    check_all("ar_walk");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
